// File: rtl/rv_trap_seq_if.sv
// rv_trap_seq_if -- bundle of every rv_trap_seq signal except clock and reset.
//   Instruction CSR access : i_instr_req/idx/data/op -> o_instr_ack
//   Trap requests          : i_exc_*, i_irq*, i_mie, i_mret
//   CSR file port          : o_csr_idx/data, o_csr_read/write/set/clear <- i_csr_rdata
//   Pipeline control       : o_stall, o_redirect, o_redirect_pc, o_busy
// slave  : the sequencer's view (i_* in, o_* out).
// master : the pipeline/CSR-file side driving the sequencer.
interface rv_trap_seq_if;
  logic        i_instr_req;
  logic [11:0] i_instr_idx;
  logic [31:0] i_instr_data;
  logic [1:0]  i_instr_op;
  logic        o_instr_ack;

  logic        i_exc_valid;
  logic [4:0]  i_exc_cause;
  logic [31:0] i_exc_pc;
  logic [31:0] i_exc_tval;
  logic        i_irq;
  logic [4:0]  i_irq_cause;
  logic [31:0] i_irq_pc;
  logic        i_mie;
  logic        i_mret;

  logic [31:0] i_csr_rdata;
  logic [11:0] o_csr_idx;
  logic [31:0] o_csr_data;
  logic        o_csr_read;
  logic        o_csr_write;
  logic        o_csr_set;
  logic        o_csr_clear;

  logic        o_stall;
  logic        o_redirect;
  logic [31:0] o_redirect_pc;
  logic        o_busy;

  modport slave (
    input  i_instr_req, i_instr_idx, i_instr_data, i_instr_op,
    input  i_exc_valid, i_exc_cause, i_exc_pc, i_exc_tval,
    input  i_irq, i_irq_cause, i_irq_pc, i_mie, i_mret, i_csr_rdata,
    output o_instr_ack, o_csr_idx, o_csr_data,
    output o_csr_read, o_csr_write, o_csr_set, o_csr_clear,
    output o_stall, o_redirect, o_redirect_pc, o_busy
  );

  modport master (
    output i_instr_req, i_instr_idx, i_instr_data, i_instr_op,
    output i_exc_valid, i_exc_cause, i_exc_pc, i_exc_tval,
    output i_irq, i_irq_cause, i_irq_pc, i_mie, i_mret, i_csr_rdata,
    input  o_instr_ack, o_csr_idx, o_csr_data,
    input  o_csr_read, o_csr_write, o_csr_set, o_csr_clear,
    input  o_stall, o_redirect, o_redirect_pc, o_busy
  );
endinterface

// File: rtl/rv_trap_seq.sv
// rv_trap_seq -- machine-mode trap / MRET sequencer in front of a CSR file.
// Owns a single CSR port. In IDLE it either accepts a trap (exception or
// enabled interrupt), accepts an MRET, or passes an instruction CSR access
// straight through in the same cycle. A trap walks mepc, mcause, mtval,
// mstatus read-modify-write and mtvec read, then redirects fetch; MRET reads
// mepc, read-modify-writes mstatus and redirects to mepc.
// Ports:
//   i_clk      clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   bus        rv_trap_seq_if.slave (requests, CSR port, stall/redirect)
// Parameter:
//   VECTORED_EN  1: interrupts honour mtvec mode 01 (base + cause*4)
module rv_trap_seq #(
  parameter bit VECTORED_EN = 1'b1
) (
  input logic          i_clk,
  input logic          i_reset_n,
  rv_trap_seq_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, T_EPC, T_CAUSE, T_TVAL, T_RDST, T_WRST, T_RDVEC, T_JUMP,
    M_RDEPC, M_RDST, M_WRST, M_JUMP
  } state_t;

  // Strobe vector order {clear, set, write, read} so an instruction op
  // code selects its strobe by a plain shift.
  localparam logic [3:0]  S_RD      = 4'b0001;
  localparam logic [3:0]  S_WR      = 4'b0010;
  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;

  state_t      state;
  logic [3:0]  strb_q;      // strobes for the current sequence state
  logic [11:0] idx_q;
  logic [31:0] data_q;
  logic        redir_q;
  logic [4:0]  cause_q;
  logic        irq_q;
  logic [31:0] tval_q;
  logic [31:0] epc_q;       // mepc with bit 0 already cleared
  logic [31:0] last_pc_q;   // last redirect target, held between redirects

  logic        idle;
  logic        trap_req;
  logic        take_instr;
  logic [31:0] vec_base;
  logic [31:0] trap_target;
  logic [3:0]  strb;
  logic [11:0] idx;
  logic [31:0] data;
  logic [31:0] rpc;

  // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r       = s;
    r[7]    = s[3];
    r[3]    = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // MRET: MIE <= MPIE, MPIE <= 1, MPP kept at M (machine-only core).
  function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r       = s;
    r[3]    = s[7];
    r[7]    = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  assign idle       = (state == IDLE);
  assign trap_req   = bus.i_exc_valid | (bus.i_irq & bus.i_mie);
  // Reset gating keeps the combinational passthrough quiet while reset is held.
  assign take_instr = idle & i_reset_n & bus.i_instr_req & ~trap_req & ~bus.i_mret;

  // mtvec arrives on i_csr_rdata during T_JUMP (read issued in T_RDVEC).
  assign vec_base    = {bus.i_csr_rdata[31:2], 2'b00};
  assign trap_target = (VECTORED_EN && irq_q && (bus.i_csr_rdata[1:0] == 2'b01))
                       ? vec_base + {25'd0, cause_q, 2'b00}
                       : vec_base;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      strb_q    <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      redir_q   <= 1'b0;
      cause_q   <= '0;
      irq_q     <= 1'b0;
      tval_q    <= '0;
      epc_q     <= '0;
      last_pc_q <= '0;
    end else begin
      // Outputs for the next state are registered here; anything not set
      // below falls back to "issue nothing".
      strb_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      redir_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.i_exc_valid) begin
            cause_q <= bus.i_exc_cause;
            irq_q   <= 1'b0;
            tval_q  <= bus.i_exc_tval;
            state   <= T_EPC;
            strb_q  <= S_WR;
            idx_q   <= A_MEPC;
            data_q  <= bus.i_exc_pc;
          end else if (bus.i_irq && bus.i_mie) begin
            cause_q <= bus.i_irq_cause;
            irq_q   <= 1'b1;
            tval_q  <= '0;
            state   <= T_EPC;
            strb_q  <= S_WR;
            idx_q   <= A_MEPC;
            data_q  <= bus.i_irq_pc;
          end else if (bus.i_mret) begin
            state  <= M_RDEPC;
            strb_q <= S_RD;
            idx_q  <= A_MEPC;
          end
        end
        T_EPC: begin
          state  <= T_CAUSE;
          strb_q <= S_WR;
          idx_q  <= A_MCAUSE;
          data_q <= {irq_q, 26'd0, cause_q};
        end
        T_CAUSE: begin
          state  <= T_TVAL;
          strb_q <= S_WR;
          idx_q  <= A_MTVAL;
          data_q <= tval_q;
        end
        T_TVAL: begin
          state  <= T_RDST;
          strb_q <= S_RD;
          idx_q  <= A_MSTATUS;
        end
        T_RDST: begin
          // Write data depends on the read returning next cycle; see data mux.
          state  <= T_WRST;
          strb_q <= S_WR;
          idx_q  <= A_MSTATUS;
        end
        T_WRST: begin
          state  <= T_RDVEC;
          strb_q <= S_RD;
          idx_q  <= A_MTVEC;
        end
        T_RDVEC: begin
          state   <= T_JUMP;
          redir_q <= 1'b1;
        end
        T_JUMP: begin
          last_pc_q <= trap_target;
          state     <= IDLE;
        end
        M_RDEPC: begin
          state  <= M_RDST;
          strb_q <= S_RD;
          idx_q  <= A_MSTATUS;
        end
        M_RDST: begin
          epc_q  <= {bus.i_csr_rdata[31:1], 1'b0};
          state  <= M_WRST;
          strb_q <= S_WR;
          idx_q  <= A_MSTATUS;
        end
        M_WRST: begin
          state   <= M_JUMP;
          redir_q <= 1'b1;
        end
        M_JUMP: begin
          last_pc_q <= epc_q;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // CSR port: passthrough in IDLE, otherwise the registered sequence
  // outputs, with the mstatus RMW data formed from the just-returned read.
  always_comb begin
    strb = strb_q;
    idx  = idx_q;
    data = data_q;
    if (take_instr) begin
      strb = S_RD << bus.i_instr_op;
      idx  = bus.i_instr_idx;
      data = bus.i_instr_data;
    end else if (state == T_WRST) begin
      data = trap_mstatus(bus.i_csr_rdata);
    end else if (state == M_WRST) begin
      data = mret_mstatus(bus.i_csr_rdata);
    end
  end

  always_comb begin
    rpc = last_pc_q;
    if (state == T_JUMP)      rpc = trap_target;
    else if (state == M_JUMP) rpc = epc_q;
  end

  assign bus.o_csr_read    = strb[0];
  assign bus.o_csr_write   = strb[1];
  assign bus.o_csr_set     = strb[2];
  assign bus.o_csr_clear   = strb[3];
  assign bus.o_csr_idx     = idx;
  assign bus.o_csr_data    = data;
  assign bus.o_instr_ack   = take_instr;
  // The accepting IDLE cycle stalls too, so fetch freezes before mepc is written.
  assign bus.o_stall       = ~idle | (i_reset_n & (trap_req | bus.i_mret));
  assign bus.o_redirect    = redir_q;
  assign bus.o_redirect_pc = rpc;
  assign bus.o_busy        = ~idle;

endmodule

// File: tb/tb_rv_trap_seq.sv
module tb_rv_trap_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv_trap_seq_if bus();
  rv_trap_seq #(.VECTORED_EN(1'b1)) dut (.i_clk(clk), .i_reset_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;
  int n_redirect = 0;

  // kind: 0 read, 1 write, 2 set, 3 clear, 4 redirect
  typedef struct {
    int          kind;
    logic [11:0] idx;
    logic [31:0] data;
  } ev_t;
  ev_t sbq[$];

  localparam int K_EXC = 0, K_IRQ = 1, K_MRET = 2, K_INSTR = 3;
  typedef struct {
    int          kind;
    logic        mie;
    logic [4:0]  cause;
    logic [31:0] pc, tval, mst0, mtvec0, mepc0;
    logic [1:0]  op;
    logic [11:0] idx;
    logic [31:0] data;
    logic [31:0] e342, emst, erpc;
    int          elat;
  } vec_t;
  vec_t tbl[12];

  // CSR file contents seen by the sequencer's reads
  logic [31:0] mst_m = 32'h0, mtvec_m = 32'h0, mepc_m = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [11:0] i, input logic [31:0] d);
    ev_t e;
    e.kind = k; e.idx = i; e.data = d;
    sbq.push_back(e);
  endtask

  task automatic push_trap(input logic [31:0] pc, input logic [31:0] c, input logic [31:0] tv,
                           input logic [31:0] mst, input logic [31:0] rpc);
    push(1, 12'h341, pc);
    push(1, 12'h342, c);
    push(1, 12'h343, tv);
    push(0, 12'h300, 32'h0);
    push(1, 12'h300, mst);
    push(0, 12'h305, 32'h0);
    push(4, 12'h000, rpc);
  endtask

  task automatic clear_inputs();
    bus.i_instr_req = 0; bus.i_instr_idx = '0; bus.i_instr_data = '0; bus.i_instr_op = '0;
    bus.i_exc_valid = 0; bus.i_exc_cause = '0; bus.i_exc_pc = '0; bus.i_exc_tval = '0;
    bus.i_irq = 0; bus.i_irq_cause = '0; bus.i_irq_pc = '0; bus.i_mie = 0; bus.i_mret = 0;
  endtask

  function automatic vec_t mk(input int k, input logic mie, input logic [4:0] c,
                              input logic [31:0] pc, input logic [31:0] tv, input logic [31:0] mst,
                              input logic [31:0] tvec, input logic [31:0] epc, input logic [31:0] e342,
                              input logic [31:0] emst, input logic [31:0] erpc, input int lat);
    vec_t v;
    v.kind = k; v.mie = mie; v.cause = c; v.pc = pc; v.tval = tv; v.mst0 = mst;
    v.mtvec0 = tvec; v.mepc0 = epc; v.op = 2'b00; v.idx = '0; v.data = '0;
    v.e342 = e342; v.emst = emst; v.erpc = erpc; v.elat = lat;
    return v;
  endfunction

  function automatic vec_t mk_i(input logic [1:0] op, input logic [11:0] idx, input logic [31:0] d);
    vec_t v;
    v = mk(K_INSTR, 1'b0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.op = op; v.idx = idx; v.data = d;
    return v;
  endfunction

  // CSR file model: read data valid the cycle after the read strobe
  always @(posedge clk) begin
    if (bus.o_csr_read) begin
      case (bus.o_csr_idx)
        12'h300: bus.i_csr_rdata <= mst_m;
        12'h305: bus.i_csr_rdata <= mtvec_m;
        12'h341: bus.i_csr_rdata <= mepc_m;
        default: bus.i_csr_rdata <= 32'h0;
      endcase
    end
  end

  // Monitor: every strobe/redirect is popped against the scoreboard
  int  mon_ns;
  ev_t mon_o, mon_e;
  always @(negedge clk) begin
    mon_ns = int'(bus.o_csr_read) + int'(bus.o_csr_write) + int'(bus.o_csr_set) + int'(bus.o_csr_clear);
    if (bus.o_busy) chk("stall_while_busy", 32'(bus.o_stall), 32'd1);
    if (mon_ns > 1 || (mon_ns == 1 && bus.o_redirect)) begin
      checks++; failures++;
      $display("FAIL strobe_overlap strobes=%0d redirect=%0b required=at_most_one", mon_ns, bus.o_redirect);
    end
    if (mon_ns != 0 || bus.o_redirect) begin
      if (bus.o_redirect) n_redirect++;
      mon_o.kind = bus.o_csr_read ? 0 : bus.o_csr_write ? 1 : bus.o_csr_set ? 2 : bus.o_csr_clear ? 3 : 4;
      mon_o.idx  = bus.o_csr_idx;
      mon_o.data = bus.o_redirect ? bus.o_redirect_pc : bus.o_csr_data;
      if (sbq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_event kind=%0d idx=0x%03h data=0x%08h required=none",
                 mon_o.kind, mon_o.idx, mon_o.data);
      end else begin
        mon_e = sbq.pop_front();
        chk("ev_kind", 32'(mon_o.kind), 32'(mon_e.kind));
        if (mon_e.kind < 4) chk($sformatf("ev_idx_%03h", mon_e.idx), 32'(mon_o.idx), 32'(mon_e.idx));
        if (mon_e.kind != 0) chk($sformatf("ev_data_k%0d_%03h", mon_e.kind, mon_e.idx), mon_o.data, mon_e.data);
      end
    end
  end

  task automatic run_vec(input int id, input vec_t v);
    int n;
    @(posedge clk); #1;
    mst_m = v.mst0; mtvec_m = v.mtvec0; mepc_m = v.mepc0;
    case (v.kind)
      K_EXC: begin
        bus.i_exc_valid = 1; bus.i_exc_cause = v.cause; bus.i_exc_pc = v.pc; bus.i_exc_tval = v.tval;
        push_trap(v.pc, v.e342, v.tval, v.emst, v.erpc);
      end
      K_IRQ: begin
        bus.i_irq = 1; bus.i_mie = v.mie; bus.i_irq_cause = v.cause; bus.i_irq_pc = v.pc;
        if (v.mie) push_trap(v.pc, v.e342, 32'h0, v.emst, v.erpc);
      end
      K_MRET: begin
        bus.i_mret = 1;
        push(0, 12'h341, 32'h0);
        push(0, 12'h300, 32'h0);
        push(1, 12'h300, v.emst);
        push(4, 12'h000, v.erpc);
      end
      default: begin
        bus.i_instr_req = 1; bus.i_instr_op = v.op; bus.i_instr_idx = v.idx; bus.i_instr_data = v.data;
        push(int'(v.op), v.idx, v.data);
      end
    endcase
    @(negedge clk);
    chk($sformatf("v%0d_accept_stall", id), 32'(bus.o_stall), 32'(v.elat != 0));
    chk($sformatf("v%0d_ack", id), 32'(bus.o_instr_ack), 32'(v.kind == K_INSTR));
    @(posedge clk); #1;
    clear_inputs();
    if (v.elat != 0) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.o_redirect && n < 20);
      chk($sformatf("v%0d_latency", id), 32'(n), 32'(v.elat));
      @(negedge clk);
      chk($sformatf("v%0d_rpc_hold", id), bus.o_redirect_pc, v.erpc);
    end else begin
      repeat (3) @(negedge clk);
    end
    chk($sformatf("v%0d_idle", id), 32'(bus.o_busy), 32'd0);
    chk($sformatf("v%0d_sb_empty", id), 32'(sbq.size()), 32'd0);
  endtask

  // All four requests at once: exception wins, instr waits, busy-time exc ignored
  task automatic seq_priority();
    int n;
    @(posedge clk); #1;
    mst_m = 32'h8; mtvec_m = 32'h8000_0001;
    bus.i_exc_valid = 1; bus.i_exc_cause = 5'd2; bus.i_exc_pc = 32'h100; bus.i_exc_tval = 32'hDEAD;
    bus.i_irq = 1; bus.i_irq_cause = 5'd7; bus.i_irq_pc = 32'h999; bus.i_mie = 1; bus.i_mret = 1;
    bus.i_instr_req = 1; bus.i_instr_op = 2'b00; bus.i_instr_idx = 12'h340;
    push_trap(32'h100, 32'h2, 32'hDEAD, 32'h1880, 32'h8000_0000);
    push(0, 12'h340, 32'h0);
    @(negedge clk);
    chk("prio_accept_stall", 32'(bus.o_stall), 32'd1);
    chk("prio_accept_ack", 32'(bus.o_instr_ack), 32'd0);
    @(posedge clk); #1;
    bus.i_exc_valid = 0; bus.i_irq = 0; bus.i_mret = 0; bus.i_mie = 0;
    n = 0;
    do begin
      @(negedge clk); n++;
      chk($sformatf("prio_busy_ack_c%0d", n), 32'(bus.o_instr_ack), 32'd0);
      if (n == 2) bus.i_exc_valid = 1;
      if (n == 4) bus.i_exc_valid = 0;
    end while (!bus.o_redirect && n < 20);
    chk("prio_latency", 32'(n), 32'd7);
    @(negedge clk);
    chk("prio_ack_after", 32'(bus.o_instr_ack), 32'd1);
    chk("prio_nostall_after", 32'(bus.o_stall), 32'd0);
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    chk("prio_sb_empty", 32'(sbq.size()), 32'd0);
  endtask

  // Reset in T_TVAL: outputs clear at once, no further events
  task automatic seq_reset_mid();
    int base;
    @(posedge clk); #1;
    mst_m = 32'h8; mtvec_m = 32'h8000_0000;
    bus.i_exc_valid = 1; bus.i_exc_cause = 5'd2; bus.i_exc_pc = 32'h100; bus.i_exc_tval = 32'hDEAD;
    push(1, 12'h341, 32'h100);
    push(1, 12'h342, 32'h2);
    @(posedge clk); #1;
    clear_inputs();
    base = n_redirect;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("rst_mid_write", 32'(bus.o_csr_write), 32'd0);
    chk("rst_mid_idx", 32'(bus.o_csr_idx), 32'd0);
    chk("rst_mid_data", bus.o_csr_data, 32'd0);
    chk("rst_mid_stall", 32'(bus.o_stall), 32'd0);
    chk("rst_mid_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_mid_rpc", bus.o_redirect_pc, 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (12) @(negedge clk);
    chk("rst_mid_no_redirect", 32'(n_redirect), 32'(base));
    chk("rst_mid_idle", 32'(bus.o_busy), 32'd0);
    chk("rst_mid_sb_empty", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk); #1;
    // Reset state with active requests present
    bus.i_instr_req = 1; bus.i_instr_op = 2'b01; bus.i_instr_idx = 12'h340; bus.i_instr_data = 32'h55;
    bus.i_exc_valid = 1;
    @(negedge clk);
    chk("reset_ack", 32'(bus.o_instr_ack), 32'd0);
    chk("reset_strobes", 32'({bus.o_csr_read, bus.o_csr_write, bus.o_csr_set, bus.o_csr_clear}), 32'd0);
    chk("reset_idx", 32'(bus.o_csr_idx), 32'd0);
    chk("reset_data", bus.o_csr_data, 32'd0);
    chk("reset_stall", 32'(bus.o_stall), 32'd0);
    chk("reset_busy", 32'(bus.o_busy), 32'd0);
    chk("reset_redirect", 32'(bus.o_redirect), 32'd0);
    chk("reset_rpc", bus.o_redirect_pc, 32'd0);
    @(posedge clk); #1;
    clear_inputs();
    rst_n = 1;

    //          kind    mie  cause pc            tval        mst0          mtvec0         mepc0         e342          emst          erpc          lat
    tbl[0]  = mk(K_EXC,  0, 5'd2,  32'h100,      32'hDEAD,   32'h8,        32'h8000_0000, 32'h0,        32'h2,        32'h1880,     32'h8000_0000, 7);
    tbl[1]  = mk(K_IRQ,  1, 5'd7,  32'h400,      32'h0,      32'h8,        32'h8000_0001, 32'h0,        32'h8000_0007, 32'h1880,    32'h8000_001C, 7);
    tbl[2]  = mk(K_EXC,  0, 5'd5,  32'h1234,     32'h77,     32'h0,        32'h8000_0001, 32'h0,        32'h5,        32'h1800,     32'h8000_0000, 7);
    tbl[3]  = mk(K_IRQ,  1, 5'd11, 32'h2000,     32'h0,      32'hFFFF_FFFF, 32'h1003,     32'h0,        32'h8000_000B, 32'hFFFF_FFF7, 32'h1000,  7);
    tbl[4]  = mk(K_IRQ,  1, 5'd3,  32'h3000,     32'h0,      32'h80,       32'hFFFF_FFFD, 32'h0,        32'h8000_0003, 32'h1800,    32'h8,         7);
    tbl[5]  = mk(K_MRET, 0, 5'd0,  32'h0,        32'h0,      32'h1880,     32'h0,         32'h203,      32'h0,        32'h1888,     32'h202,       4);
    tbl[6]  = mk(K_MRET, 0, 5'd0,  32'h0,        32'h0,      32'h0,        32'h0,         32'h8000_0001, 32'h0,       32'h1880,     32'h8000_0000, 4);
    tbl[7]  = mk_i(2'b01, 12'h340, 32'h55);
    tbl[8]  = mk_i(2'b00, 12'h300, 32'h0);
    tbl[9]  = mk_i(2'b10, 12'h304, 32'h88);
    tbl[10] = mk_i(2'b11, 12'h304, 32'h8);
    tbl[11] = mk(K_IRQ,  0, 5'd7,  32'h400,      32'h0,      32'h8,        32'h8000_0001, 32'h0,        32'h0,        32'h0,        32'h0,         0);

    for (int i = 0; i < 12; i++) run_vec(i, tbl[i]);
    seq_priority();
    seq_reset_mid();
    run_vec(20, tbl[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rv_trap_seq.md
RV_TRAP_SEQ -- requirements
Module: rv_trap_seq

Interface
REQ-001 Parameter VECTORED_EN, default 1, enables vectored mtvec mode (mtvec[1:0]==01) for interrupts; 0 treats every mode as direct.
REQ-002 i_clk  in  1  single clock; all state updates on the rising edge.
REQ-003 i_reset_n  in  1  reset, asynchronous, active-low.
REQ-004 i_instr_req  in  1  instruction CSR access request; held until acked.
REQ-005 i_instr_idx  in  12  CSR address of the instruction access.
REQ-006 i_instr_data  in  32  write/set/clear operand.
REQ-007 i_instr_op  in  2  00 read, 01 write, 10 set, 11 clear.
REQ-008 o_instr_ack  out  1  instruction access issued this cycle.
REQ-009 i_exc_valid  in  1  synchronous exception request.
REQ-010 i_exc_cause  in  5  exception cause code.
REQ-011 i_exc_pc  in  32  PC of the trapping instruction.
REQ-012 i_exc_tval  in  32  trap value.
REQ-013 i_irq  in  1  pending interrupt; i_irq_cause  in  5  its cause; i_irq_pc  in  32  resume PC.
REQ-014 i_mie  in  1  mstatus.MIE as currently held by the CSR file.
REQ-015 i_mret  in  1  MRET retire request.
REQ-016 i_csr_rdata  in  32  CSR file read data, valid the cycle after o_csr_read.
REQ-017 o_csr_idx  out  12  CSR address; o_csr_data  out  32  operand.
REQ-018 o_csr_read, o_csr_write, o_csr_set, o_csr_clear  out  1 each  CSR port strobes.
REQ-019 o_stall  out  1  freeze fetch/decode.
REQ-020 o_redirect  out  1  one-cycle PC redirect strobe; o_redirect_pc  out  32  target.
REQ-021 o_busy  out  1  state is not IDLE.

Function
REQ-022 States: IDLE, T_EPC, T_CAUSE, T_TVAL, T_RDST, T_WRST, T_RDVEC, T_JUMP, M_RDEPC, M_RDST, M_WRST, M_JUMP.
REQ-023 Sampling in IDLE only, priority: i_exc_valid > (i_irq & i_mie) > i_mret > i_instr_req.
REQ-024 Trap accept in IDLE: latch cause, PC (i_exc_pc or i_irq_pc), tval (i_exc_tval or 0), interrupt flag; go to T_EPC.
REQ-025 Trap sequence, one state per cycle: T_EPC write 0x341 = PC; T_CAUSE write 0x342 = {irq,26'b0,cause}; T_TVAL write 0x343 = tval; T_RDST read 0x300; T_WRST write 0x300; T_RDVEC read 0x305; T_JUMP redirect; return to IDLE.
REQ-026 T_WRST data = i_csr_rdata with bit7 <= bit3, bit3 <= 0, bits[12:11] <= 11, all other bits unchanged.
REQ-027 T_JUMP target = {rdata[31:2],00} + (cause<<2) when VECTORED_EN, interrupt and rdata[1:0]==01; else {rdata[31:2],00}; 32-bit modulo add.
REQ-028 MRET sequence: M_RDEPC read 0x341; M_RDST latch i_csr_rdata as EPC, read 0x300; M_WRST write 0x300 with bit3 <= bit7, bit7 <= 1, bits[12:11] <= 11; M_JUMP redirect to {EPC[31:1],0}.
REQ-029 Instruction access in IDLE: same-cycle passthrough of idx/data/op to the CSR port, o_instr_ack=1, state stays IDLE; op 00 asserts o_csr_read only.
REQ-030 Exactly one CSR strobe at most per cycle; strobes 0 and o_csr_idx/o_csr_data 0 in states that issue nothing.
REQ-031 o_stall=1 in every non-IDLE state and in the IDLE cycle that accepts a trap or MRET.
REQ-032 o_redirect high exactly one cycle (T_JUMP/M_JUMP); o_redirect_pc holds the last target otherwise.
REQ-033 Requests arriving while busy: exception/irq/mret ignored, instr request not acked; upstream re-presents after redirect.
REQ-034 Trap sequence length 7 cycles accept-to-redirect; MRET 4 cycles.

Reset
REQ-035 Reset asserted: state IDLE; all outputs 0, including o_redirect_pc; latched cause/PC/tval/EPC 0.
REQ-036 Reset asserted mid-sequence aborts immediately; no further CSR strobes, no redirect after release.

Verification
REQ-037 Exception cause 2, pc 0x100, tval 0xDEAD, mtvec 0x8000_0000 -> writes 0x341=0x100, 0x342=0x2, 0x343=0xDEAD, redirect 0x8000_0000 on cycle 7.
REQ-038 Interrupt cause 7, i_mie=1, mtvec 0x8000_0001 -> 0x342=0x8000_0007, redirect 0x8000_001C; same with i_mie=0 -> no sequence.
REQ-039 mstatus 0x0000_0008 at trap -> written 0x0000_1880; MRET with mstatus 0x1880, mepc 0x203 -> mstatus 0x1888, redirect 0x202.
REQ-040 i_exc_valid, i_irq, i_mret, i_instr_req all high in IDLE -> exception path taken, no ack until return to IDLE.
REQ-041 Instr write idx 0x340 data 0x55 in IDLE -> same cycle o_csr_write=1, idx 0x340, data 0x55, ack=1; no stall.
REQ-042 Reset asserted in T_TVAL -> outputs 0 asynchronously, no redirect, IDLE after release.
